// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Option MULTICYCLE_MEM_WAIT_EN adds memory wait states to FETCH, MEMREAD and MEMWR.
package rv32i_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, JAL, BEQ
   } state_e;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCB_WD    = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       pcupdate;
      logic       branch;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
   } ctrl_t;

   // States that access memory and may have to wait for it.
   function automatic logic is_mem_state(state_e s);
      return (s == FETCH) || (s == MEMREAD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/mc_state_decode.sv
// Moore output decode: maps the control state to the raw datapath control vector.
module mc_state_decode
   import rv32i_ctrl_pkg::*;
(
   input  state_e state_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         FETCH: begin
            ctrl_o.irwrite   = 1'b1;
            ctrl_o.pcupdate  = 1'b1;
            ctrl_o.alusrca   = SRCA_PC;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.aluop     = ALUOP_ADD;
            ctrl_o.resultsrc = RES_ALURES;
         end
         DECODE: begin
            ctrl_o.alusrca = SRCA_OLDPC;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = ALUOP_ADD;
         end
         MEMADR: begin
            ctrl_o.alusrca = SRCA_RD1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = ALUOP_ADD;
         end
         MEMREAD: begin
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.adrsrc    = 1'b1;
         end
         MEMWB: begin
            ctrl_o.resultsrc = RES_DATA;
            ctrl_o.regwrite  = 1'b1;
         end
         MEMWR: begin
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.adrsrc    = 1'b1;
            ctrl_o.memwrite  = 1'b1;
         end
         EXECR: begin
            ctrl_o.alusrca = SRCA_RD1;
            ctrl_o.alusrcb = SRCB_WD;
            ctrl_o.aluop   = ALUOP_FUNCT;
         end
         EXECI: begin
            ctrl_o.alusrca = SRCA_RD1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.regwrite  = 1'b1;
         end
         JAL: begin
            ctrl_o.alusrca   = SRCA_OLDPC;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.aluop     = ALUOP_ADD;
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.pcupdate  = 1'b1;
         end
         BEQ: begin
            ctrl_o.alusrca   = SRCA_RD1;
            ctrl_o.alusrcb   = SRCB_WD;
            ctrl_o.aluop     = ALUOP_SUB;
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.branch    = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle RV32I main control FSM with retired-instruction counter.
// Option MULTICYCLE_MEM_WAIT_EN adds MEM_READY and stalls the memory states on it.
module rv32i_multicycle_ctrl
   import rv32i_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [6:0]       OP,
   input  logic             ZERO,
`ifdef MULTICYCLE_MEM_WAIT_EN
   input  logic             MEM_READY,
`endif
   output logic             PCWRITE,
   output logic             ADRSRC,
   output logic             MEMWRITE,
   output logic             IRWRITE,
   output logic             REGWRITE,
   output logic [1:0]       RESULTSRC,
   output logic [1:0]       ALUSRCA,
   output logic [1:0]       ALUSRCB,
   output logic [1:0]       ALUOP,
   output logic             ILLEGAL,
   output logic [CNT_W-1:0] INSTRET
);

   state_e           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   ctrl_t            ctrl;
   logic             mem_ok;
   logic             hold;

`ifdef MULTICYCLE_MEM_WAIT_EN
   assign mem_ok = MEM_READY;
`else
   assign mem_ok = 1'b1;
`endif

   assign hold = is_mem_state(state_q) & ~mem_ok;

   mc_state_decode u_decode (
      .state_i (state_q),
      .ctrl_o  (ctrl)
   );

   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      instret_d = instret_q;
      case (state_q)
         FETCH:   if (!hold) state_d = DECODE;
         DECODE: begin
            case (OP)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECR;
               OP_ITYPE:     state_d = EXECI;
               OP_JAL:       state_d = JAL;
               OP_BEQ:       state_d = BEQ;
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR:  state_d = (OP == OP_LW) ? MEMREAD : MEMWR;
         MEMREAD: if (!hold) state_d = MEMWB;
         MEMWB: begin
            state_d   = FETCH;
            instret_d = instret_q + CNT_W'(1);
         end
         MEMWR: begin
            if (!hold) begin
               state_d   = FETCH;
               instret_d = instret_q + CNT_W'(1);
            end
         end
         EXECR, EXECI, JAL: state_d = ALUWB;
         ALUWB, BEQ: begin
            state_d   = FETCH;
            instret_d = instret_q + CNT_W'(1);
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   // Everything is forced quiet while reset is held, independent of state.
   always_comb begin
      PCWRITE   = 1'b0;
      ADRSRC    = 1'b0;
      MEMWRITE  = 1'b0;
      IRWRITE   = 1'b0;
      REGWRITE  = 1'b0;
      RESULTSRC = 2'b00;
      ALUSRCA   = 2'b00;
      ALUSRCB   = 2'b00;
      ALUOP     = 2'b00;
      ILLEGAL   = 1'b0;
      if (RSTn) begin
         PCWRITE   = (ctrl.pcupdate | (ctrl.branch & ZERO)) & ~hold;
         ADRSRC    = ctrl.adrsrc;
         MEMWRITE  = ctrl.memwrite & ~hold;
         IRWRITE   = ctrl.irwrite & ~hold;
         REGWRITE  = ctrl.regwrite;
         RESULTSRC = ctrl.resultsrc;
         ALUSRCA   = ctrl.alusrca;
         ALUSRCB   = ctrl.alusrcb;
         ALUOP     = ctrl.aluop;
         ILLEGAL   = illegal_q;
      end
   end

   assign INSTRET = instret_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench for rv32i_multicycle_ctrl; per-instruction cycle tables feed a queue.
// Build with MULTICYCLE_MEM_WAIT_EN defined to also exercise memory wait states.
module tb_rv32i_multicycle_ctrl;

   localparam int unsigned CNT_W = 4;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;
   localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MW = 5;
   localparam int PH_ER = 6, PH_EI = 7, PH_AWB = 8, PH_J = 9, PH_B = 10;

   logic             CLK = 1'b0;
   logic             RSTn;
   logic [6:0]       OP;
   logic             ZERO;
`ifdef MULTICYCLE_MEM_WAIT_EN
   logic             MEM_READY;
`endif
   logic             PCWRITE, ADRSRC, MEMWRITE, IRWRITE, REGWRITE, ILLEGAL;
   logic [1:0]       RESULTSRC, ALUSRCA, ALUSRCB, ALUOP;
   logic [CNT_W-1:0] INSTRET;

   rv32i_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .OP        (OP),
      .ZERO      (ZERO),
`ifdef MULTICYCLE_MEM_WAIT_EN
      .MEM_READY (MEM_READY),
`endif
      .PCWRITE   (PCWRITE),
      .ADRSRC    (ADRSRC),
      .MEMWRITE  (MEMWRITE),
      .IRWRITE   (IRWRITE),
      .REGWRITE  (REGWRITE),
      .RESULTSRC (RESULTSRC),
      .ALUSRCA   (ALUSRCA),
      .ALUSRCB   (ALUSRCB),
      .ALUOP     (ALUOP),
      .ILLEGAL   (ILLEGAL),
      .INSTRET   (INSTRET)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [13:0]      v;
      logic [CNT_W-1:0] cnt;
      string            tag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   model_cnt = 0;
   bit   prev_ill = 1'b0;

   // {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb, aluop, illegal}
   function automatic logic [13:0] mk(bit pc, bit adr, bit mw, bit ir, bit rw,
                                      logic [1:0] res, logic [1:0] a, logic [1:0] b,
                                      logic [1:0] aop);
      return {pc, adr, mw, ir, rw, res, a, b, aop, 1'b0};
   endfunction

   function automatic logic [13:0] ph_vec(int ph, bit z);
      case (ph)
         PH_F:    return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00);
         PH_D:    return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
         PH_MA:   return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
         PH_MR:   return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
         PH_MWB:  return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00);
         PH_MW:   return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
         PH_ER:   return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
         PH_EI:   return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10);
         PH_AWB:  return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
         PH_J:    return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
         PH_B:    return mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01);
         default: return '0;
      endcase
   endfunction

   function automatic bit is_legal(logic [6:0] op);
      return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
             op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011;
   endfunction

   function automatic logic [6:0] kind_op(int kind);
      case (kind)
         K_LW:    return 7'b0000011;
         K_SW:    return 7'b0100011;
         K_R:     return 7'b0110011;
         K_I:     return 7'b0010011;
         K_JAL:   return 7'b1101111;
         K_BEQ:   return 7'b1100011;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic push(logic [13:0] v, string tag);
      exp_t e;
      e.v   = v;
      e.cnt = model_cnt[CNT_W-1:0];
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // rst_at: phase index at which reset is asserted for one cycle, aborting the instruction.
   task automatic run_instr(int kind, bit z, logic [6:0] op_in, int rst_at);
      int          ph[$];
      bit          first;
      logic [13:0] v;
      ph = '{PH_F, PH_D};
      case (kind)
         K_LW:  begin ph.push_back(PH_MA); ph.push_back(PH_MR); ph.push_back(PH_MWB); end
         K_SW:  begin ph.push_back(PH_MA); ph.push_back(PH_MW); end
         K_R:   begin ph.push_back(PH_ER); ph.push_back(PH_AWB); end
         K_I:   begin ph.push_back(PH_EI); ph.push_back(PH_AWB); end
         K_JAL: begin ph.push_back(PH_J); ph.push_back(PH_AWB); end
         K_BEQ: ph.push_back(PH_B);
         default: ;
      endcase
      first = 1'b1;
      for (int i = 0; i < ph.size(); i++) begin
         ZERO = (ph[i] == PH_B) ? z : 1'($urandom);
         OP   = (ph[i] == PH_D || ph[i] == PH_MA) ? op_in : 7'($urandom);
         if (i == rst_at) begin
            RSTn = 1'b0;
            push('0, "reset_abort");
            tick();
            RSTn = 1'b1;
            model_cnt = 0;
            prev_ill = 1'b0;
            return;
         end
`ifdef MULTICYCLE_MEM_WAIT_EN
         if (ph[i] == PH_F || ph[i] == PH_MR || ph[i] == PH_MW) begin
            int n;
            n = (ph[i] == PH_F && kind == K_LW) ? 3 : int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) begin
               MEM_READY = 1'b0;
               v = ph_vec(ph[i], z);
               v[13] = 1'b0;
               v[11] = 1'b0;
               v[10] = 1'b0;
               v[0] = first & prev_ill;
               first = 1'b0;
               push(v, "mem_wait");
               tick();
               ZERO = 1'($urandom);
               OP   = 7'($urandom);
            end
            MEM_READY = 1'b1;
         end
`endif
         v = ph_vec(ph[i], z);
         v[0] = first & prev_ill;
         first = 1'b0;
         push(v, $sformatf("kind%0d_ph%0d", kind, ph[i]));
         tick();
      end
      if (kind == K_ILL) begin
         prev_ill = 1'b1;
      end else begin
         prev_ill = 1'b0;
         model_cnt = (model_cnt + 1) % (1 << CNT_W);
      end
   endtask

   task automatic run_kind(int kind, bit z);
      logic [6:0] op;
      op = kind_op(kind);
      if (kind == K_ILL) begin
         op = 7'($urandom);
         while (is_legal(op)) op = 7'($urandom);
      end
      run_instr(kind, z, op, -1);
   endtask

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         if ({PCWRITE, ADRSRC, MEMWRITE, IRWRITE, REGWRITE, RESULTSRC, ALUSRCA, ALUSRCB,
              ALUOP, ILLEGAL} !== mon_e.v) begin
            errors++;
            $display("FAIL %s ctrl got=%b exp=%b", mon_e.tag,
                     {PCWRITE, ADRSRC, MEMWRITE, IRWRITE, REGWRITE, RESULTSRC, ALUSRCA,
                      ALUSRCB, ALUOP, ILLEGAL}, mon_e.v);
         end
         checks++;
         if (INSTRET !== mon_e.cnt) begin
            errors++;
            $display("FAIL %s instret got=%0d exp=%0d", mon_e.tag, INSTRET, mon_e.cnt);
         end
      end
   end

   initial begin
      RSTn = 1'b0;
      OP   = 7'($urandom);
      ZERO = 1'b1;
`ifdef MULTICYCLE_MEM_WAIT_EN
      MEM_READY = 1'b1;
`endif
      tick();
      for (int i = 0; i < 3; i++) begin
         ZERO = 1'($urandom);
         OP   = 7'($urandom);
         push('0, "in_reset");
         tick();
      end
      RSTn = 1'b1;

      run_kind(K_LW, 1'b0);
      run_kind(K_BEQ, 1'b1);
      run_kind(K_BEQ, 1'b0);
      run_kind(K_JAL, 1'b0);
      run_kind(K_ILL, 1'b0);
      run_kind(K_ILL, 1'b0);
      run_kind(K_R, 1'b0);
      for (int i = 0; i < 17; i++) run_kind(K_SW, 1'($urandom));
      for (int i = 0; i < 60; i++) run_kind(int'($urandom_range(0, 6)), 1'($urandom));
      run_instr(K_SW, 1'b0, kind_op(K_SW), 3);
      for (int i = 0; i < 10; i++) run_kind(int'($urandom_range(0, 6)), 1'($urandom));

      @(negedge CLK);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I datapath. Decodes the opcode latched in the instruction register and sequences each instruction over 3–5 cycles. Drives the 3:1 source muxes (ALUSrcA, ALUSrcB, ResultSrc), the memory address mux and all datapath write enables. Also keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter INSTRET

Ports:
CLK  input  1  system clock; all state updates on rising edge
RSTn  input  1  synchronous active-low reset; sampled on rising CLK
OP  input  7  opcode, Instr[6:0], from instruction register
ZERO  input  1  ALU zero flag
PCWRITE  output  1  PC register enable
ADRSRC  output  1  memory address mux: 0 = PC, 1 = ALUOut
MEMWRITE  output  1  data memory write enable
IRWRITE  output  1  instruction register / OldPC enable
REGWRITE  output  1  register file write enable
RESULTSRC  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSRCA  output  2  00 = PC, 01 = OldPC, 10 = RD1 (A reg)
ALUSRCB  output  2  00 = WriteData, 01 = ImmExt, 10 = constant 4
ALUOP  output  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded
ILLEGAL  output  1  one-cycle pulse on unsupported opcode
INSTRET  output  CNT_W  count of retired instructions

Behaviour:
- Moore FSM. All outputs except PCWRITE decode from the state register only. PCWRITE = PCUPDATE | (BRANCH & ZERO), where PCUPDATE and BRANCH are internal state decodes.
- Reset (RSTn=0 at edge): state <= FETCH, INSTRET <= 0.
- While RSTn is low, combinationally force PCWRITE, IRWRITE, MEMWRITE, REGWRITE and ILLEGAL to 0, and all selects to 00.
- Reset mid-instruction aborts the instruction. No counter increment.
- Unlisted outputs are 0 in each state.
- States, outputs and transitions:
  - FETCH: ADRSRC=0, IRWRITE=1, ALUSRCA=00, ALUSRCB=10, ALUOP=00, RESULTSRC=10, PCUPDATE=1 -> DECODE
  - DECODE: ALUSRCA=01, ALUSRCB=01, ALUOP=00. Next state by OP:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other -> FETCH with ILLEGAL=1 (registered, asserted during the next FETCH cycle)
  - MEMADR: ALUSRCA=10, ALUSRCB=01, ALUOP=00. OP=0000011 -> MEMREAD; OP=0100011 -> MEMWR
  - MEMREAD: RESULTSRC=00, ADRSRC=1 -> MEMWB
  - MEMWB: RESULTSRC=01, REGWRITE=1 -> FETCH
  - MEMWR: RESULTSRC=00, ADRSRC=1, MEMWRITE=1 -> FETCH
  - EXECR: ALUSRCA=10, ALUSRCB=00, ALUOP=10 -> ALUWB
  - EXECI: ALUSRCA=10, ALUSRCB=01, ALUOP=10 -> ALUWB
  - ALUWB: RESULTSRC=00, REGWRITE=1 -> FETCH
  - JAL: ALUSRCA=01, ALUSRCB=10, ALUOP=00, RESULTSRC=00, PCUPDATE=1 -> ALUWB
  - BEQ: ALUSRCA=10, ALUSRCB=00, ALUOP=01, RESULTSRC=00, BRANCH=1 -> FETCH
- Instruction latency in cycles:
  - lw 5
  - sw 4
  - R / I / jal 4
  - beq 3
  - illegal 2 (FETCH + DECODE)
- OP is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- INSTRET increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB or BEQ. It does not increment on the illegal path. It wraps from 2^CNT_W−1 to 0 without a flag.
- Unreachable state encodings go to FETCH.

Optional Feature:
MULTICYCLE_MEM_WAIT_EN
- Defined: adds input MEM_READY (1 bit). FETCH, MEMREAD and MEMWR hold their state and outputs until MEM_READY=1. While held, PCWRITE, IRWRITE and MEMWRITE are gated to 0; the enables fire only in the cycle MEM_READY=1.
- Undefined: no port, single-cycle memory, behaviour exactly as above.

Decomposition:
- Package rv32i_ctrl_pkg contains:
  - state enum (FETCH..BEQ)
  - opcode localparams OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ
  - select encodings SRCA_PC/OLDPC/RD1, SRCB_WD/IMM/FOUR, RES_ALUOUT/DATA/ALURES, ALUOP_ADD/SUB/FUNCT
- Sub-module mc_state_decode: purely combinational, state -> output control vector. The FSM top module holds the state register, next-state logic, ILLEGAL flop and INSTRET.

Test Plan:
1. Reset: hold RSTn=0 for 3 cycles, then release → first cycle FETCH with IRWRITE=1, PCWRITE=1, ALUSRCB=10, RESULTSRC=10; INSTRET=0. During reset all enables are 0.
2. lw (OP=0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; REGWRITE=1 only in cycle 5 with RESULTSRC=01; INSTRET=1 afterwards.
3. beq (OP=1100011) with ZERO=1 → PCWRITE=1 in cycle 3; repeat with ZERO=0 → PCWRITE=0 in cycle 3; both take 3 cycles, and INSTRET rises by 2 total.
4. jal → PCWRITE=1 in cycle 3, then ALUWB with REGWRITE=1; OP=0000000 → ILLEGAL pulses once, back in FETCH after 2 cycles, INSTRET unchanged.
5. CNT_W=4: retire 17 sw instructions → INSTRET=1 (wrap); assert RSTn=0 during MEMWR → no MEMWRITE that cycle, state=FETCH, INSTRET=0.
6. With MULTICYCLE_MEM_WAIT_EN: MEM_READY=0 for 3 cycles in FETCH → state held, IRWRITE=0 and PCWRITE=0; MEM_READY=1 → both enables high for exactly 1 cycle, then DECODE.
